// File: rtl/nios_nios2_gen2_0_cpu_oci_dct_packer.sv
// Packs DCT trace entries into fixed-width frames and queues them in a small FIFO.
// A test_ending request flushes any partial frame, then waits for the FIFO to drain.
module nios_nios2_gen2_0_cpu_oci_dct_packer #(
    parameter int ENTRY_W    = 2,
    parameter int DEPTH      = 15,
    parameter int CNT_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       entry_valid,
    input  logic [ENTRY_W-1:0]         entry_data,
    input  logic                       test_ending,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [ENTRY_W*DEPTH-1:0]   dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       overflow,
    output logic                       test_has_ended
);

    localparam int FW = ENTRY_W * DEPTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [FW-1:0]    data;
        logic [CNT_W-1:0] cnt;
    } frame_t;

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} state_t;

    state_t           state, state_nx;
    logic [FW-1:0]    acc, acc_nx;
    logic [CNT_W-1:0] acc_cnt, acc_cnt_nx;
    frame_t           mem [FIFO_DEPTH];
    frame_t           head, push_frame;
    logic [PW:0]      wptr, rptr;
    logic             empty, full, pop, space, push, drop;

    // Extra pointer bit separates full from empty.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign pop   = !empty && frame_ready;
    assign space = !full || pop;

    assign head           = mem[rptr[PW-1:0]];
    assign frame_valid    = !empty;
    assign dct_buffer     = empty ? '0 : head.data;
    assign dct_count      = empty ? '0 : head.cnt;
    assign test_has_ended = (state == ENDED);

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        acc_cnt_nx = acc_cnt;
        push       = 1'b0;
        drop       = 1'b0;
        push_frame = '0;
        case (state)
            RUN: begin
                if (entry_valid) begin
                    acc_nx[int'(acc_cnt)*ENTRY_W +: ENTRY_W] = entry_data;
                    acc_cnt_nx = acc_cnt + 1'b1;
                    if (acc_cnt == CNT_W'(DEPTH-1)) begin
                        push_frame = '{data: acc_nx, cnt: CNT_W'(DEPTH)};
                        push       = space;
                        drop       = !space;
                        acc_nx     = '0;
                        acc_cnt_nx = '0;
                    end
                end
                if (test_ending) state_nx = FLUSH;
            end
            FLUSH: begin
                // Partial frame waits for room rather than being dropped.
                if (acc_cnt == '0) begin
                    state_nx = DRAIN;
                end else if (space) begin
                    push_frame = '{data: acc, cnt: acc_cnt};
                    push       = 1'b1;
                    acc_nx     = '0;
                    acc_cnt_nx = '0;
                    state_nx   = DRAIN;
                end
            end
            DRAIN: begin
                if (empty) state_nx = ENDED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            acc      <= '0;
            acc_cnt  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            acc_cnt <= acc_cnt_nx;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= push_frame;
    end

endmodule

// File: tb/tb_nios_nios2_gen2_0_cpu_oci_dct_packer.sv
// Bench for the DCT packer: vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_nios_nios2_gen2_0_cpu_oci_dct_packer;

    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        entry_valid = 1'b0;
    logic [1:0]  entry_data = '0;
    logic        test_ending = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_has_ended;

    nios_nios2_gen2_0_cpu_oci_dct_packer dut (
        .clk(clk), .reset_n(reset_n),
        .entry_valid(entry_valid), .entry_data(entry_data),
        .test_ending(test_ending),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .overflow(overflow), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [29:0] b;
        int          c;
    } mfr_t;

    localparam int P_RUN = 0, P_FLUSH = 1, P_DRAIN = 2, P_ENDED = 3;

    mfr_t       mq[$];
    logic [1:0] ment[$];
    int         mphase = P_RUN;
    bit         movf = 1'b0;
    int         mpre;

    function automatic mfr_t mk(input logic [1:0] q[$]);
        mfr_t r;
        r.b = '0;
        foreach (q[i]) r.b = r.b | (30'(q[i]) << (2*i));
        r.c = q.size();
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            ment.delete();
            mphase = P_RUN;
            movf   = 1'b0;
        end else begin
            mpre = mq.size();
            if (mpre > 0 && frame_ready) void'(mq.pop_front());
            case (mphase)
                P_RUN: begin
                    if (entry_valid) begin
                        ment.push_back(entry_data);
                        if (ment.size() == 15) begin
                            if (mq.size() < FD) mq.push_back(mk(ment));
                            else movf = 1'b1;
                            ment.delete();
                        end
                    end
                    if (test_ending) mphase = P_FLUSH;
                end
                P_FLUSH: begin
                    if (ment.size() == 0) mphase = P_DRAIN;
                    else if (mq.size() < FD) begin
                        mq.push_back(mk(ment));
                        ment.delete();
                        mphase = P_DRAIN;
                    end
                end
                P_DRAIN: if (mpre == 0) mphase = P_ENDED;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("mon_valid", 32'(frame_valid), 32'(mq.size() > 0));
        chk("mon_buf", 32'(dct_buffer), 32'(mq.size() > 0 ? mq[0].b : 30'h0));
        chk("mon_cnt", 32'(dct_count), 32'(mq.size() > 0 ? mq[0].c : 0));
        chk("mon_ovf", 32'(overflow), 32'(movf));
        chk("mon_end", 32'(test_has_ended), 32'(mphase == P_ENDED));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic v, input logic [1:0] d, input logic r, input logic te);
        @(negedge clk);
        entry_valid = v;
        entry_data  = d;
        frame_ready = r;
        test_ending = te;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        entry_valid = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        r;
        logic        te;
        logic        efv;
        logic [3:0]  ecnt;
        logic [29:0] ebuf;
    } vec_t;

    vec_t        tbl[17];
    logic [29:0] eb[5];
    logic [1:0]  dd;
    logic [3:0]  lastc;
    logic [29:0] lastb;
    int          n;
    int          rp;

    initial begin
        // reset state
        #2;
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_buf", 32'(dct_buffer), 32'd0);
        chk("rst_cnt", 32'(dct_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_end", 32'(test_has_ended), 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // full frame of 0,1,2,3,... entries
        for (int k = 0; k < 14; k++) tbl[k] = '{1'b1, 2'(k % 4), 1'b1, 1'b0, 1'b0, 4'd0, 30'h0};
        tbl[14] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 4'd15, 30'h24E4E4E4};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd15, 30'h24E4E4E4};
        tbl[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 30'h0};
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].te);
            chk($sformatf("tbl%0d_valid", i), 32'(frame_valid), 32'(tbl[i].efv));
            chk($sformatf("tbl%0d_cnt", i), 32'(dct_count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_buf", i), 32'(dct_buffer), 32'(tbl[i].ebuf));
        end

        // overflow: five frames into a four-deep FIFO
        do_reset();
        for (int f = 0; f < 5; f++) begin
            eb[f] = '0;
            for (int k = 0; k < 15; k++) begin
                dd = 2'($urandom_range(0, 3));
                eb[f] = eb[f] | (30'(dd) << (2*k));
                cyc(1'b1, dd, 1'b0, 1'b0);
            end
        end
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("ovf_fr%0d_buf", f), 32'(dct_buffer), 32'(eb[f]));
            chk($sformatf("ovf_fr%0d_cnt", f), 32'(dct_count), 32'd15);
            cyc(1'b0, 2'd0, 1'b1, 1'b0);
        end
        chk("ovf_empty", 32'(frame_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // push into a full FIFO with a simultaneous pop
        do_reset();
        for (int k = 0; k < 74; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b1, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("sim_ovf", 32'(overflow), 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (frame_valid) n++;
            cyc(1'b0, 2'd0, 1'b1, 1'b0);
        end
        chk("sim_frames", 32'(n), 32'd4);

        // flush partial frame
        do_reset();
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        n = 0;
        while (!frame_valid && n < 5) begin
            cyc(1'b0, 2'd0, 1'b0, 1'b0);
            n++;
        end
        chk("fl_valid", 32'(frame_valid), 32'd1);
        chk("fl_cnt", 32'(dct_count), 32'd3);
        chk("fl_buf", 32'(dct_buffer), 32'h1F);
        chk("fl_not_ended", 32'(test_has_ended), 32'd0);
        cyc(1'b0, 2'd0, 1'b1, 1'b0);
        n = 0;
        while (!test_has_ended && n < 3) begin
            cyc(1'b0, 2'd0, 1'b0, 1'b0);
            n++;
        end
        chk("fl_ended", 32'(test_has_ended), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'd2, 1'b1, 1'b1);
        chk("fl_hold_end", 32'(test_has_ended), 32'd1);
        chk("fl_ignore", 32'(frame_valid), 32'd0);

        // flush with a full FIFO must stall, not drop
        do_reset();
        for (int k = 0; k < 60; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("ff_stall_valid", 32'(frame_valid), 32'd1);
        chk("ff_stall_ovf", 32'(overflow), 32'd0);
        chk("ff_stall_end", 32'(test_has_ended), 32'd0);
        n = 0;
        lastc = '0;
        lastb = '0;
        for (int i = 0; i < 30; i++) begin
            if (test_has_ended) break;
            if (frame_valid) begin
                n++;
                lastc = dct_count;
                lastb = dct_buffer;
            end
            cyc(1'b0, 2'd0, 1'b1, 1'b0);
        end
        chk("ff_frames", 32'(n), 32'd5);
        chk("ff_last_cnt", 32'(lastc), 32'd2);
        chk("ff_last_buf", 32'(lastb), 32'h9);
        chk("ff_ended", 32'(test_has_ended), 32'd1);
        chk("ff_ovf", 32'(overflow), 32'd0);

        // reset with frames queued
        do_reset();
        for (int k = 0; k < 30; k++) cyc(1'b1, 2'(k % 4), 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        chk("mr_before", 32'(frame_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_valid", 32'(frame_valid), 32'd0);
        chk("mr_end", 32'(test_has_ended), 32'd0);
        chk("mr_buf", 32'(dct_buffer), 32'd0);
        chk("mr_cnt", 32'(dct_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        eb[0] = '0;
        for (int k = 0; k < 15; k++) begin
            dd = 2'($urandom_range(0, 3));
            eb[0] = eb[0] | (30'(dd) << (2*k));
            cyc(1'b1, dd, 1'b0, 1'b0);
        end
        chk("mr_new_valid", 32'(frame_valid), 32'd1);
        chk("mr_new_cnt", 32'(dct_count), 32'd15);
        chk("mr_new_buf", 32'(dct_buffer), 32'(eb[0]));

        // randomized run against the model
        do_reset();
        rp = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rp = 10;
                    1: rp = 50;
                    default: rp = 95;
                endcase
            end
            if ($urandom_range(0, 399) == 0) do_reset();
            else cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 249) == 0));
        end

        cyc(1'b0, 2'd0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_nios2_gen2_0_cpu_oci_dct_packer.md
NIOS_NIOS2_GEN2_0_CPU_OCI_DCT_PACKER -- requirements
Module: nios_nios2_gen2_0_cpu_oci_dct_packer

Interface
REQ-001 The block SHALL have parameter ENTRY_W, default 2: width of one direct-control-transfer (DCT) trace entry.
REQ-002 The block SHALL have parameter DEPTH, default 15: entries per frame; frame width FW = ENTRY_W*DEPTH (default 30).
REQ-003 The block SHALL have parameter CNT_W, default 4: count width; CNT_W SHALL be large enough to hold DEPTH.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: frame FIFO depth, power of two, >=2.
REQ-005 The block SHALL have port clk, input, 1: single clock; all state SHALL be updated on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 The block SHALL have port entry_valid, input, 1: entry_data is presented this cycle.
REQ-008 The block SHALL have port entry_data, input, ENTRY_W: trace entry.
REQ-009 The block SHALL have port test_ending, input, 1: single-cycle flush request.
REQ-010 The block SHALL have port frame_valid, output, 1: FIFO head is valid.
REQ-011 The block SHALL have port frame_ready, input, 1: consumer accepts the head.
REQ-012 The block SHALL have port dct_buffer, output, FW: FIFO head frame; entry k SHALL occupy bits [k*ENTRY_W +: ENTRY_W].
REQ-013 The block SHALL have port dct_count, output, CNT_W: number of valid entries in the head frame (1..DEPTH).
REQ-014 The block SHALL have port overflow, output, 1: sticky flag, set when a frame is dropped.
REQ-015 The block SHALL have port test_has_ended, output, 1: flush complete and FIFO drained.

Function
REQ-016 The accumulator SHALL write an accepted entry into slot acc_cnt and then increment acc_cnt; slots >= acc_cnt SHALL read as zero in a pushed frame.
REQ-017 An entry SHALL be accepted only in state RUN when entry_valid=1.
REQ-018 When an accepted entry makes acc_cnt reach DEPTH, the block SHALL push {acc, DEPTH} into the FIFO in the same cycle and clear acc and acc_cnt to 0.
REQ-019 A pushed frame SHALL be visible as frame_valid=1 on the cycle after the push when the FIFO was empty (1-cycle latency).
REQ-020 If a full-frame push finds the FIFO full and no pop occurs in that cycle, the frame SHALL be dropped and overflow set; a simultaneous pop SHALL free space so the push succeeds.
REQ-021 A pop SHALL occur when frame_valid=1 and frame_ready=1; dct_buffer and dct_count SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-023 The FSM SHALL have states RUN, FLUSH, DRAIN and ENDED.
REQ-024 In RUN, test_ending=1 SHALL cause a transition to FLUSH; an entry accepted in the same cycle SHALL be included in the flushed data.
REQ-025 In FLUSH with acc_cnt>0, the block SHALL push the partial frame {acc, acc_cnt} when the FIFO has space and then enter DRAIN.
REQ-026 In FLUSH, the block SHALL never drop a frame; it SHALL stall until the FIFO has space.
REQ-027 In FLUSH with acc_cnt=0, the block SHALL enter DRAIN without a push.
REQ-028 In DRAIN, when the FIFO is empty, the block SHALL enter ENDED.
REQ-029 ENDED SHALL drive test_has_ended=1 and hold it until reset; entries and test_ending SHALL be ignored.
REQ-030 test_ending SHALL be ignored in FLUSH, DRAIN and ENDED.
REQ-031 overflow SHALL remain set until reset.

Reset
REQ-032 While reset_n=0, the block SHALL be in state RUN, and acc, acc_cnt and the FIFO pointers SHALL be 0.
REQ-033 While reset_n=0, frame_valid, overflow and test_has_ended SHALL be 0, dct_buffer SHALL be 0 and dct_count SHALL be 0.
REQ-034 Reset asserted mid-frame or mid-flush SHALL discard all pending frames without emitting any output.
REQ-035 Deassertion of reset_n SHALL be synchronised externally; the block SHALL take no action on the first clock edge beyond resuming RUN.

Verification
REQ-036 Full frame: with frame_ready=1, send 15 valid entries 0,1,2,3,0,1,... -> one cycle after the 15th, frame_valid=1, dct_count=15, dct_buffer[1:0]=0, dct_buffer[3:2]=1, dct_buffer[29:28]=2.
REQ-037 Overflow: with frame_ready=0, send 5 full frames (75 entries) -> 4 frames are held, overflow=1, and draining yields frames 1-4 in order.
REQ-038 Simultaneous push and pop: fill the FIFO, then complete frame 5 in the same cycle as frame_ready=1 -> no drop, overflow=0.
REQ-039 Flush partial: send 3 entries (3,3,1) then test_ending -> frame dct_count=3, dct_buffer=30'h1F; test_has_ended rises one cycle after that pop.
REQ-040 Flush with a full FIFO: FIFO full, 2 pending entries, test_ending, frame_ready=0 for 10 cycles -> no drop, block stalls in FLUSH, all 5 frames are delivered, then test_has_ended=1.
REQ-041 Reset mid-operation: pull reset_n low with 2 frames queued -> frame_valid=0 immediately and test_has_ended=0; after release, the next 15 entries produce a clean frame.
